// File: rtl/mbist_pkg.sv
// rtl/mbist_pkg.sv - March C- element table, FSM states and data backgrounds
package mbist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int NUM_ELEMS = 6;

  // Background selectors; the top replicates them across the data width.
  localparam logic DATA0 = 1'b0;
  localparam logic DATA1 = 1'b1;

  typedef struct packed {
    logic up;        // 1: ascending address order, 0: descending
    logic two_ops;   // 1: (read, write) per address, 0: single op
    logic first_wr;  // single-op elements: 1 = write, 0 = read
    logic exp_bg;    // background expected by the element's read
    logic wr_bg;     // background written by the element's write
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{up: 1'b1, two_ops: 1'b0, first_wr: 1'b1, exp_bg: DATA0, wr_bg: DATA0};
      3'd1:    return '{up: 1'b1, two_ops: 1'b1, first_wr: 1'b0, exp_bg: DATA0, wr_bg: DATA1};
      3'd2:    return '{up: 1'b1, two_ops: 1'b1, first_wr: 1'b0, exp_bg: DATA1, wr_bg: DATA0};
      3'd3:    return '{up: 1'b0, two_ops: 1'b1, first_wr: 1'b0, exp_bg: DATA0, wr_bg: DATA1};
      3'd4:    return '{up: 1'b0, two_ops: 1'b1, first_wr: 1'b0, exp_bg: DATA1, wr_bg: DATA0};
      default: return '{up: 1'b1, two_ops: 1'b0, first_wr: 1'b0, exp_bg: DATA0, wr_bg: DATA0};
    endcase
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// rtl/mbist_march_ctrl_if.sv - memory-side bus between the MBIST engine and the memory
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();

  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output write_read,
    output address,
    output wdata,
    input  rdata
  );

  modport slave (
    input  write_read,
    input  address,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/mbist_resp_cmp.sv
// rtl/mbist_resp_cmp.sv - 2-stage expected-data pipeline, compare and first-fail capture
module mbist_resp_cmp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_exp,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [2:0]            push_elem,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syn,
  output logic [7:0]            err_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] exp;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            elem;
  } stage_t;

  stage_t                s1, s2;
  logic                  mis;
  logic [DATA_WIDTH-1:0] syn;

  // Case inequality per bit so an X/Z read bit shows up as a syndrome 1.
  always_comb begin
    syn = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      syn[i] = (rdata[i] !== s2.exp[i]);
    end
    mis = s2.valid && (rdata !== s2.exp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_syn  <= '0;
      err_cnt   <= '0;
    end else if (clr) begin
      s1        <= '0;
      s2        <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_syn  <= '0;
      err_cnt   <= '0;
    end else begin
      s1 <= '{valid: push_valid, exp: push_exp, addr: push_addr, elem: push_elem};
      s2 <= s1;
      if (mis) begin
        fail <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
        if (!fail) begin
          fail_addr <= s2.addr;
          fail_elem <= s2.elem;
          fail_syn  <= syn;
        end
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// rtl/mbist_march_ctrl.sv - March C- MBIST engine: FSM, element/op/address counters, memory drive
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  mbist_march_ctrl_if.master    mem,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_WIDTH-1:0] fail_syn,
  output logic [7:0]            err_cnt
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam logic [2:0]            LAST_ELEM = 3'(NUM_ELEMS - 1);

  state_t                state, state_nx;
  logic [2:0]            elem, elem_nx;
  logic                  op, op_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic                  drain, drain_nx;

  elem_cfg_t cfg, cfg_next;
  logic      last_op, at_end, start_acc, is_write, push_valid;

  assign cfg       = elem_cfg(elem);
  assign cfg_next  = elem_cfg(elem + 3'd1);
  assign last_op   = !cfg.two_ops || op;
  assign at_end    = cfg.up ? (addr == LAST_ADDR) : (addr == '0);
  assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      elem  <= '0;
      op    <= 1'b0;
      addr  <= '0;
      drain <= 1'b0;
    end else begin
      state <= state_nx;
      elem  <= elem_nx;
      op    <= op_nx;
      addr  <= addr_nx;
      drain <= drain_nx;
    end
  end

  always_comb begin
    state_nx = state;
    elem_nx  = elem;
    op_nx    = op;
    addr_nx  = addr;
    drain_nx = drain;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          state_nx = S_SETUP;
          elem_nx  = '0;
          op_nx    = 1'b0;
          addr_nx  = '0;
          drain_nx = 1'b0;
        end
      end
      S_SETUP: begin
        state_nx = S_RUN;
        op_nx    = 1'b0;
      end
      S_RUN: begin
        if (!last_op) begin
          op_nx = 1'b1;
        end else begin
          op_nx = 1'b0;
          // Address counter stops at the element's terminal address; it never wraps.
          if (at_end) begin
            if (elem == LAST_ELEM) begin
              state_nx = S_DRAIN;
              drain_nx = 1'b0;
            end else begin
              state_nx = S_SETUP;
              elem_nx  = elem + 3'd1;
              addr_nx  = cfg_next.up ? '0 : LAST_ADDR;
            end
          end else begin
            addr_nx = cfg.up ? addr + ADDR_WIDTH'(1) : addr - ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain) begin
          state_nx = S_DONE;
        end else begin
          drain_nx = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    is_write   = 1'b0;
    push_valid = 1'b0;
    unique case (state)
      S_SETUP, S_DRAIN: busy = 1'b1;
      S_RUN: begin
        busy       = 1'b1;
        is_write   = cfg.two_ops ? op : cfg.first_wr;
        push_valid = !is_write;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // wdata follows the element register, so it is already valid during SETUP.
  assign mem.write_read = is_write;
  assign mem.address    = addr;
  assign mem.wdata      = {DATA_WIDTH{cfg.wr_bg}};

  mbist_resp_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_resp_cmp (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_acc),
    .push_valid(push_valid),
    .push_exp  ({DATA_WIDTH{cfg.exp_bg}}),
    .push_addr (addr),
    .push_elem (elem),
    .rdata     (mem.rdata),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_syn  (fail_syn),
    .err_cnt   (err_cnt)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb/tb_mbist_march_ctrl.sv - directed bench for the March C- MBIST engine with a fault-injectable memory model
module tb_mbist_march_ctrl;

  localparam int DW        = 8;
  localparam int AW        = 4;
  localparam int CAP       = 15;
  localparam int TRACE_LEN = 166;
  localparam int DONE_CYC  = 168;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_syn;
  logic [7:0]    err_cnt;

  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mbist_march_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .CAPACITY  (CAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem      (bus),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem),
    .fail_syn (fail_syn),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // fault_mode 1: cell 5 unwritable and reads all ones; 2: bit 3 stuck-at-1 at cell 9
  int            fault_mode = 0;
  logic [DW-1:0] mem [0:CAP];
  logic [DW-1:0] wd_q, rd_q;

  function automatic logic [DW-1:0] cell_read(input logic [AW-1:0] a);
    if (fault_mode == 1 && a == 4'd5) return 8'hFF;
    if (fault_mode == 2 && a == 4'd9) return mem[a] | 8'h08;
    return mem[a];
  endfunction

  always @(posedge clk) begin
    wd_q <= bus.wdata;
    if (bus.write_read && !(fault_mode == 1 && bus.address == 4'd5)) mem[bus.address] <= wd_q;
    rd_q      <= cell_read(bus.address);
    bus.rdata <= rd_q;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.write_read, bus.address, bus.wdata, busy, done, fail,
                fail_addr, fail_elem, fail_syn, err_cnt});
  endfunction

  logic [4:0] trace [$];
  logic [4:0] exp_trace [$];

  function automatic void build_trace();
    logic       down;
    logic [3:0] a;
    exp_trace.delete();
    for (int e = 0; e < 6; e++) begin
      down = (e == 3 || e == 4);
      exp_trace.push_back({1'b0, down ? 4'd15 : 4'd0});
      for (int i = 0; i < 16; i++) begin
        a = down ? 4'(15 - i) : 4'(i);
        if (e == 0) begin
          exp_trace.push_back({1'b1, a});
        end else if (e == 5) begin
          exp_trace.push_back({1'b0, a});
        end else begin
          exp_trace.push_back({1'b0, a});
          exp_trace.push_back({1'b1, a});
        end
      end
    end
  endfunction

  // Pulses start at edge 0, then counts edges until done (or stop_at / a 400-cycle bound).
  task automatic run_test(input int p1, input int p2, input int stop_at, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    trace.delete();
    check("busy_after_start", 64'(busy), 64'd1);
    check("start_clears", 64'({done, fail, err_cnt, fail_addr, fail_elem, fail_syn}), 64'd0);
    while (!done && cyc < 400 && cyc != stop_at) begin
      if (cyc < TRACE_LEN) trace.push_back({bus.write_read, bus.address});
      start = (cyc == p1 || cyc == p2);
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int nmis;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    fault_mode = 0;
    run_test(-1, -1, -1, cyc);
    check("ff_done_cycle", 64'(cyc), 64'(DONE_CYC));
    check("ff_busy_at_done", 64'(busy), 64'd0);
    check("ff_fail", 64'(fail), 64'd0);
    check("ff_err_cnt", 64'(err_cnt), 64'd0);
    build_trace();
    check("ff_trace_len", 64'(trace.size()), 64'(TRACE_LEN));
    nmis = 0;
    for (int i = 0; i < trace.size() && i < exp_trace.size(); i++) begin
      if (trace[i] !== exp_trace[i]) nmis++;
    end
    check("ff_trace_mismatches", 64'(nmis), 64'd0);

    fault_mode = 1;
    run_test(-1, -1, -1, cyc);
    check("c5_done_cycle", 64'(cyc), 64'(DONE_CYC));
    check("c5_fail", 64'(fail), 64'd1);
    check("c5_fail_elem", 64'(fail_elem), 64'd1);
    check("c5_fail_addr", 64'(fail_addr), 64'd5);
    check("c5_fail_syn", 64'(fail_syn), 64'hFF);
    check("c5_err_cnt", 64'(err_cnt), 64'd3);

    fault_mode = 2;
    run_test(-1, -1, -1, cyc);
    check("sa1_done_cycle", 64'(cyc), 64'(DONE_CYC));
    check("sa1_fail_elem", 64'(fail_elem), 64'd1);
    check("sa1_fail_addr", 64'(fail_addr), 64'd9);
    check("sa1_fail_syn", 64'(fail_syn), 64'h08);
    check("sa1_err_cnt", 64'(err_cnt), 64'd3);

    run_test(-1, -1, 100, cyc);
    check("mid_e3_cycle", 64'(cyc), 64'd100);
    check("mid_e3_fail", 64'(fail), 64'd1);
    check("mid_e3_err_cnt", 64'(err_cnt), 64'd2);
    check("mid_e3_wdata", 64'(bus.wdata), 64'hFF);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", outs(), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    fault_mode = 0;
    run_test(-1, -1, -1, cyc);
    check("post_reset_done_cycle", 64'(cyc), 64'(DONE_CYC));
    check("post_reset_fail", 64'(fail), 64'd0);
    check("post_reset_err_cnt", 64'(err_cnt), 64'd0);

    run_test(40, 120, -1, cyc);
    check("busy_start_done_cycle", 64'(cyc), 64'(DONE_CYC));
    check("busy_start_done", 64'(done), 64'd1);
    check("busy_start_fail", 64'(fail), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
